// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for serial_addsub.
// master: start/mode/a/b out, busy/done/s/cout/ovf(/z) in; slave mirrors it.
// Optional z (zero flag) exists only with SERIAL_ADDSUB_ZERO_FLAG_EN defined.
interface serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic             z;
`endif

    modport master (
        output start, mode, a, b,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        input  z,
`endif
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, mode, a, b,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        output z,
`endif
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle LSB-first adder/subtractor, BITS_PER_CYCLE bits per RUN cycle.
// Ports: clk, rst (sync, active-high), bus (serial_addsub_if.slave):
//   start/mode/a/b in; busy/done/s/cout/ovf out (+ z if
//   SERIAL_ADDSUB_ZERO_FLAG_EN is defined: z = result==0, registered with s).
module serial_addsub #(
    parameter int WIDTH          = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          rst,
    serial_addsub_if.slave bus
);
    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             last;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;

    logic [B:0]       sum;
    logic [WIDTH+B-1:0] res_wide;
    logic [WIDTH-1:0] res_next;
    logic             c_msb;

    // One chunk of the shared carry chain.
    always_comb begin
        sum = {1'b0, opa[B-1:0]} + {1'b0, opb[B-1:0]}
            + {{B{1'b0}}, carry};
        // Carry into the top bit of this chunk, recovered from its sum bit.
        c_msb = sum[B-1] ^ opa[B-1] ^ opb[B-1];
        // Sum chunk enters the result from the MSB end.
        res_wide = {sum[B-1:0], res};
        res_next = res_wide[WIDTH+B-1:B];
        last = (cnt == CW'(N - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN:  if (last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy = (state == RUN) || (state == DONE);
        bus.done = (state == DONE);
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

    // Datapath: operand/result shift registers and carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa   <= bus.a;
                        // Subtract = add inverted b with carry-in 1.
                        opb   <= bus.b ^ {WIDTH{bus.mode}};
                        carry <= bus.mode;
                        cnt   <= '0;
                        res   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> B;
                    opb   <= opb >> B;
                    res   <= res_next;
                    carry <= sum[B];
                    cnt   <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: only touched on entry to DONE or by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == RUN && last) begin
            s_q    <= res_next;
            cout_q <= sum[B];
            ovf_q  <= c_msb ^ sum[B];
        end
    end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
        end else if (state == RUN && last) begin
            z_q <= (res_next == '0);
        end
    end

    assign bus.z = z_q;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=4/BPC=1 table plus
// hold-start and mid-RUN reset sequences, and a WIDTH=8/BPC=2 instance.
module tb_serial_addsub;
    localparam int N4 = 4;
    localparam int N8 = 4;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(4)) bus4 ();
    serial_addsub_if #(.WIDTH(8)) bus8 ();

    serial_addsub #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    typedef struct {
        logic       mode;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       cout;
        logic       ovf;
        logic       z;
    } vec_t;

    vec_t vt[8];

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_res4(input string tag, input vec_t v);
        chk({tag, ".s"}, 32'(bus4.s), 32'(v.s));
        chk({tag, ".cout"}, 32'(bus4.cout), 32'(v.cout));
        chk({tag, ".ovf"}, 32'(bus4.ovf), 32'(v.ovf));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        chk({tag, ".z"}, 32'(bus4.z), 32'(v.z));
`endif
    endtask

    // Issue one op on dut4; hold=1 keeps start high and scrambles inputs.
    task automatic run4(input vec_t v, input bit hold, input string tag);
        int dn;
        dn = 0;
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.mode  = v.mode;
        bus4.a     = v.a;
        bus4.b     = v.b;
        @(posedge clk);
        for (int j = 0; j <= N4 + 1; j++) begin
            @(negedge clk);
            if (hold) begin
                bus4.a    = ~bus4.a;
                bus4.b    = bus4.b + 4'd3;
                bus4.mode = ~bus4.mode;
            end else begin
                bus4.start = 1'b0;
            end
            if (bus4.done) dn++;
            chk({tag, ".busy"}, 32'(bus4.busy), 32'(j <= N4));
            chk({tag, ".done"}, 32'(bus4.done), 32'(j == N4));
            if (j >= N4) chk_res4(tag, v);
        end
        bus4.start = 1'b0;
        chk({tag, ".ndone"}, 32'(dn), 32'd1);
    endtask

    task automatic run8(input logic m, input logic [7:0] va, vb,
                        input logic [7:0] es, input logic ec,
                        input logic eo, input string tag);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.mode  = m;
        bus8.a     = va;
        bus8.b     = vb;
        @(posedge clk);
        for (int j = 0; j <= N8 + 1; j++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            chk({tag, ".busy"}, 32'(bus8.busy), 32'(j <= N8));
            chk({tag, ".done"}, 32'(bus8.done), 32'(j == N8));
        end
        chk({tag, ".s"}, 32'(bus8.s), 32'(es));
        chk({tag, ".cout"}, 32'(bus8.cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(bus8.ovf), 32'(eo));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        vec_t v;

        //          mode  a      b      s      co    ov    z
        vt[0] = '{1'b1, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1};
        vt[1] = '{1'b1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};
        vt[7] = '{1'b0, 4'h5, 4'h4, 4'h9, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        bus4.start = 1'b0; bus4.mode = 1'b0; bus4.a = '0; bus4.b = '0;
        bus8.start = 1'b0; bus8.mode = 1'b0; bus8.a = '0; bus8.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        v = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        chk("rst.busy", 32'(bus4.busy), 32'd0);
        chk("rst.done", 32'(bus4.done), 32'd0);
        chk_res4("rst", v);

        for (int i = 0; i < 8; i++) begin
            run4(vt[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Start held high and inputs scrambled through op 2.
        run4(vt[1], 1'b1, "hold");
        @(negedge clk);
        chk("hold.idle", 32'(bus4.busy), 32'd0);

        // Reset during the second RUN cycle of op 3.
        run4(vt[3], 1'b0, "pre");
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.mode  = vt[2].mode;
        bus4.a     = vt[2].a;
        bus4.b     = vt[2].b;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst.busy", 32'(bus4.busy), 32'd0);
        chk("mrst.done", 32'(bus4.done), 32'd0);
        v = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        chk_res4("mrst", v);
        dn = 0;
        for (int j = 0; j < N4 + 2; j++) begin
            @(negedge clk);
            if (bus4.done) dn++;
        end
        chk("mrst.ndone", 32'(dn), 32'd0);

        run8(1'b0, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, "w8add");
        run8(1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, "w8sub");
        run8(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "w8ovf");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
